button_debounce_ctrl: RTL and testbench

Multi-button debounce and event controller for the button input path. Passes raw pad inputs through the team's 2-flop `synchronizer`. A single shared sample-tick counter then sequences per-button saturating debounce counters. Produces a clean level plus one-cycle press/release pulses (and optionally long-press pulses) for downstream FSMs.

---
 rtl/button_debounce_ctrl.sv | 141 ++++++++++++++
 tb/tb_button_debounce_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_ctrl.sv
// Multi-button debounce and event controller: 2-flop sync, shared sample tick,
// saturating per-button counters, press/release pulses. Long-press: BUTTON_LONG_PRESS_EN.

module synchronizer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  // No reset: output is not consumed before the first sample tick.
  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end
endmodule

module button_debounce_ctrl #(
  parameter int unsigned WIDTH          = 1,
  parameter int unsigned SAMPLE_CNT_MAX = 62500,
  parameter int unsigned PULSE_CNT_MAX  = 200,
  parameter int unsigned LONG_CNT_MAX   = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] buttons_async,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic [WIDTH-1:0] btn_long
);
  localparam int unsigned TW = $clog2(SAMPLE_CNT_MAX);
  localparam int unsigned CW = $clog2(PULSE_CNT_MAX + 1);

  logic [WIDTH-1:0] sync;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;

  synchronizer #(.WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .d   (buttons_async),
    .q   (sync)
  );

  assign tick = (tick_cnt == TW'(SAMPLE_CNT_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // A single low sample releases; only sustained highs build up to a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
      btn_level <= '0;
    end else if (tick) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (!sync[i]) begin
          cnt[i]       <= '0;
          btn_level[i] <= 1'b0;
        end else if (cnt[i] < CW'(PULSE_CNT_MAX)) begin
          cnt[i] <= cnt[i] + CW'(1);
          if (cnt[i] == CW'(PULSE_CNT_MAX - 1)) begin
            btn_level[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Edge detect stage followed by the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d     <= '0;
      rise_r      <= '0;
      fall_r      <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      level_d     <= btn_level;
      rise_r      <= btn_level & ~level_d;
      fall_r      <= ~btn_level & level_d;
      btn_press   <= rise_r;
      btn_release <= fall_r;
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LONG_CNT_MAX + 1);

  logic [LW-1:0]    long_cnt [WIDTH];
  logic [WIDTH-1:0] at_max;
  logic [WIDTH-1:0] at_max_d;

  always_comb begin
    at_max = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      at_max[i] = (long_cnt[i] == LW'(LONG_CNT_MAX));
    end
  end

  // Clears on the same edge btn_level falls, so a release never fires a late pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        long_cnt[i] <= '0;
      end
      at_max_d <= '0;
      btn_long <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (!btn_level[i] || (tick && !sync[i])) begin
          long_cnt[i] <= '0;
        end else if (tick && !at_max[i]) begin
          long_cnt[i] <= long_cnt[i] + LW'(1);
        end
      end
      at_max_d <= at_max;
      btn_long <= at_max & ~at_max_d;
    end
  end
`else
  // LONG_CNT_MAX is at least 1, so this is a constant zero.
  assign btn_long = {WIDTH{LONG_CNT_MAX == 0}};
`endif

endmodule

// File: tb/tb_button_debounce_ctrl.sv
// Directed bench for button_debounce_ctrl with an event scoreboard (WIDTH=2, ticks of 4 clk).
// Long-press expectations follow BUTTON_LONG_PRESS_EN.

module tb_button_debounce_ctrl;
  logic       clk;
  logic       rst;
  logic [1:0] buttons;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_long;

  int n_pass      = 0;
  int n_total     = 0;
  int press0_seen = 0;
  int long_seen   = 0;

  typedef struct packed {
    logic [1:0] press;
    logic [1:0] rel;
  } ev_t;
  ev_t exp_q[$];

`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [1:0] LONG_AT_PULSE = 2'b01;
  localparam int         LONG_PULSES   = 1;
`else
  localparam logic [1:0] LONG_AT_PULSE = 2'b00;
  localparam int         LONG_PULSES   = 0;
`endif

  button_debounce_ctrl #(
    .WIDTH          (2),
    .SAMPLE_CNT_MAX (4),
    .PULSE_CNT_MAX  (3),
    .LONG_CNT_MAX   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .buttons_async (buttons),
    .btn_level     (btn_level),
    .btn_press     (btn_press),
    .btn_release   (btn_release),
    .btn_long      (btn_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic [1:0] p, input logic [1:0] r);
    ev_t e;
    e.press = p;
    e.rel   = r;
    exp_q.push_back(e);
  endtask

  task automatic wait_level(input logic [1:0] exp, input int budget, input string tag);
    int k = 0;
    while (btn_level !== exp && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, 32'(btn_level), 32'(exp));
  endtask

  // Releases rst with buttons=01 held; edge numbers count from the deassert edge.
  task automatic press_from_reset();
    push_ev(2'b01, 2'b00);
    @(posedge clk);
    #1 rst = 1'b0;
    step(2);
    chk("tick_low_edge2", 32'(dut.tick), 32'd0);
    step(1);
    chk("tick_high_edge3", 32'(dut.tick), 32'd1);
    step(8);
    chk("level_low_edge11", 32'(btn_level), 32'd0);
    step(1);
    chk("level_high_edge12", 32'(btn_level), 32'b01);
    step(1);
    chk("press_low_edge13", 32'(btn_press), 32'd0);
    step(1);
    chk("press_high_edge14", 32'(btn_press), 32'b01);
    step(1);
    chk("press_low_edge15", 32'(btn_press), 32'd0);
  endtask

  // Scoreboard: every nonzero press/release cycle must match the next queued event.
  always @(negedge clk) begin
    ev_t e;
    if (btn_long != 2'b00) long_seen++;
    if (btn_press[0]) press0_seen++;
    if ((btn_press | btn_release) != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 32'({btn_press, btn_release}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("event_press", 32'(btn_press), 32'(e.press));
        chk("event_release", 32'(btn_release), 32'(e.rel));
      end
    end
  end

  initial begin
    int k;
    int base;
    int found;

    rst     = 1'b1;
    buttons = 2'b01;
    step(3);
    chk("reset_outputs", 32'({btn_level, btn_press, btn_release, btn_long}), 32'd0);
    chk("reset_tick_cnt", 32'(dut.tick_cnt), 32'd0);

    press_from_reset();

    // Release: sync at edge 17, tick at 16 still sees high, level falls at 20.
    push_ev(2'b00, 2'b01);
    buttons = 2'b00;
    step(4);
    chk("rel_level_edge19", 32'(btn_level), 32'b01);
    step(1);
    chk("rel_level_edge20", 32'(btn_level), 32'b00);
    step(2);
    chk("rel_pulse_edge22", 32'(btn_release), 32'b01);
    step(1);
    chk("rel_pulse_edge23", 32'(btn_release), 32'b00);
    chk("rel_no_extra_press", 32'(press0_seen), 32'd1);

    // Bounce: toggle every 3 cycles, then hold high.
    base = press0_seen;
    for (int t = 0; t < 14; t++) begin
      buttons[0] = ~buttons[0];
      step(3);
    end
    chk("bounce_no_press", 32'(press0_seen), 32'(base));
    push_ev(2'b01, 2'b00);
    buttons[0] = 1'b1;
    found = 0;
    for (int t = 0; t < 18 && found == 0; t++) begin
      step(1);
      if (btn_press[0]) found = 1;
    end
    chk("bounce_press_in_window", 32'(found), 32'd1);
    step(4);
    chk("bounce_single_press", 32'(press0_seen), 32'(base + 1));

    push_ev(2'b00, 2'b01);
    buttons = 2'b00;
    wait_level(2'b00, 12, "bounce_release_level");
    step(3);

    // Simultaneous press on both bits, then release of bit 1 only.
    push_ev(2'b11, 2'b00);
    buttons = 2'b11;
    k = 0;
    while (btn_press == 2'b00 && k < 24) begin
      step(1);
      k++;
    end
    chk("sim_press", 32'(btn_press), 32'b11);
    step(2);
    push_ev(2'b00, 2'b10);
    buttons = 2'b01;
    k = 0;
    while (btn_release == 2'b00 && k < 16) begin
      step(1);
      k++;
    end
    chk("sim_release", 32'(btn_release), 32'b10);
    chk("sim_level_after_rel", 32'(btn_level), 32'b01);
    step(2);

    push_ev(2'b00, 2'b01);
    buttons = 2'b00;
    wait_level(2'b00, 12, "pre_midrst_level");
    step(3);

    // Mid-operation reset with cnt[0]=2 and tick counter at 2.
    buttons = 2'b01;
    k = 0;
    while (!(dut.cnt[0] == 2 && dut.tick_cnt == 2) && k < 24) begin
      step(1);
      k++;
    end
    chk("midrst_reached", 32'(k < 24), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", 32'({btn_level, btn_press, btn_release, btn_long}), 32'd0);
    chk("midrst_cnt0", 32'(dut.cnt[0]), 32'd0);
    chk("midrst_tick_cnt", 32'(dut.tick_cnt), 32'd0);
    step(2);
    press_from_reset();

    // Long press: counter hits max on edge 20, pulse on edge 21, then none while held.
    base = long_seen;
    step(5);
    chk("long_edge20", 32'(btn_long), 32'd0);
    step(1);
    chk("long_edge21", 32'(btn_long), 32'(LONG_AT_PULSE));
    step(1);
    chk("long_edge22", 32'(btn_long), 32'd0);
    step(40);
    chk("long_pulse_count", 32'(long_seen - base), 32'(LONG_PULSES));

    push_ev(2'b00, 2'b01);
    buttons = 2'b00;
    wait_level(2'b00, 12, "final_release_level");
    step(4);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
